// File: rtl/mesi_isc_pkg.sv
// Shared command encodings, tracker state type and broadcast helpers for the
// mesi_isc broadcast-coherence monitor.
package mesi_isc_pkg;

  localparam logic [2:0] MBUS_NOP      = 3'd0;
  localparam logic [2:0] MBUS_WR       = 3'd1;
  localparam logic [2:0] MBUS_RD       = 3'd2;
  localparam logic [2:0] MBUS_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_RD_BROAD = 3'd4;

  localparam logic [2:0] CBUS_NOP      = 3'd0;
  localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_EN_RD    = 3'd4;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_WAIT,
    TRK_HOLD
  } trk_state_e;

  function automatic logic is_bcast(input logic [2:0] cmd);
    return (cmd == MBUS_WR_BROAD) || (cmd == MBUS_RD_BROAD);
  endfunction

  function automatic logic [2:0] bcast_snoop(input logic [2:0] cmd);
    return (cmd == MBUS_RD_BROAD) ? CBUS_RD_SNOOP : CBUS_WR_SNOOP;
  endfunction

endpackage

// File: rtl/mesi_isc_bcast_tracker.sv
// Per-source broadcast tracker: captures one broadcast, watches the coherence
// bus for the matching snoops and reports completion or timeout.
module mesi_isc_bcast_tracker
  import mesi_isc_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 100,
  parameter int unsigned CNT_W      = $clog2(TIMEOUT + 1),
  parameter int unsigned SRC        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [2:0]             mbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]  mbus_addr_i,
  input  logic [NUM_CORES*3-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]  cbus_addr_i,
  output logic                   capture_c,
  output logic                   done_c,
  output logic                   timeout_c,
  output logic [CNT_W-1:0]       latency_c,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [NUM_CORES-1:0]   missing_o,
  output logic [CNT_W-1:0]       last_latency_o
);

  trk_state_e             state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  eff_addr;
  logic [2:0]             exp_q;
  logic [2:0]             eff_exp;
  logic [NUM_CORES-1:0]   pend_q;
  logic [NUM_CORES-1:0]   eff_pend;
  logic [NUM_CORES-1:0]   pend_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic                   active;

  // On the capture cycle the freshly sampled command/address are matched directly.
  always_comb begin
    capture_c = (state == TRK_IDLE) && enable_i && is_bcast(mbus_cmd_i);
    active    = capture_c || (state == TRK_WAIT);
    eff_addr  = capture_c ? mbus_addr_i : addr_q;
    eff_exp   = capture_c ? bcast_snoop(mbus_cmd_i) : exp_q;
    eff_pend  = capture_c ? ~(NUM_CORES'(1) << SRC) : pend_q;
    latency_c = capture_c ? '0 : cnt_q;
    pend_nxt  = eff_pend;
    for (int c = 0; c < NUM_CORES; c++) begin
      if ((cbus_cmd_i[3*c +: 3] == eff_exp) && (cbus_addr_i == eff_addr)) begin
        pend_nxt[c] = 1'b0;
      end
    end
    done_c    = active && (pend_nxt == '0);
    timeout_c = active && !done_c && (latency_c == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= TRK_IDLE;
      addr_q         <= '0;
      exp_q          <= '0;
      pend_q         <= '0;
      cnt_q          <= '0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      missing_o      <= '0;
      last_latency_o <= '0;
    end else begin
      done_o    <= done_c;
      timeout_o <= timeout_c;
      if (capture_c) begin
        addr_q    <= mbus_addr_i;
        exp_q     <= bcast_snoop(mbus_cmd_i);
        missing_o <= '0;
      end
      if (active) begin
        pend_q <= pend_nxt;
        if (done_c) begin
          last_latency_o <= latency_c;
          state          <= TRK_HOLD;
        end else if (timeout_c) begin
          missing_o <= pend_nxt;
          state     <= TRK_HOLD;
        end else begin
          cnt_q <= latency_c + CNT_W'(1);
          state <= TRK_WAIT;
        end
      end else if ((state == TRK_HOLD) && !is_bcast(mbus_cmd_i)) begin
        // Wait for the requester to drop the command so it is not recaptured.
        state <= TRK_IDLE;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_bcast_monitor.sv
// Broadcast-coherence monitor: one tracker per source core plus shared
// broadcast count, maximum latency and sticky error.
module mesi_isc_bcast_monitor
  import mesi_isc_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 100,
  parameter int unsigned CNT_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic                            clear_i,
  input  logic [NUM_CORES*3-1:0]          mbus_cmd_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] mbus_addr_i,
  input  logic [NUM_CORES*3-1:0]          cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]           cbus_addr_i,
  output logic [NUM_CORES-1:0]            done_o,
  output logic [NUM_CORES-1:0]            timeout_o,
  output logic [NUM_CORES*NUM_CORES-1:0]  missing_o,
  output logic [NUM_CORES*CNT_W-1:0]      last_latency_o,
  output logic [CNT_W-1:0]                max_latency_o,
  output logic [15:0]                     bcast_count_o,
  output logic                            err_sticky_o
);

  logic [NUM_CORES-1:0]       cap_c;
  logic [NUM_CORES-1:0]       done_c;
  logic [NUM_CORES-1:0]       to_c;
  logic [NUM_CORES*CNT_W-1:0] lat_c;

  for (genvar s = 0; s < NUM_CORES; s++) begin : g_trk
    mesi_isc_bcast_tracker #(
      .NUM_CORES (NUM_CORES),
      .ADDR_WIDTH(ADDR_WIDTH),
      .TIMEOUT   (TIMEOUT),
      .CNT_W     (CNT_W),
      .SRC       (s)
    ) u_trk (
      .clk           (clk),
      .rst           (rst),
      .enable_i      (enable_i),
      .mbus_cmd_i    (mbus_cmd_i[3*s +: 3]),
      .mbus_addr_i   (mbus_addr_i[ADDR_WIDTH*s +: ADDR_WIDTH]),
      .cbus_cmd_i    (cbus_cmd_i),
      .cbus_addr_i   (cbus_addr_i),
      .capture_c     (cap_c[s]),
      .done_c        (done_c[s]),
      .timeout_c     (to_c[s]),
      .latency_c     (lat_c[CNT_W*s +: CNT_W]),
      .done_o        (done_o[s]),
      .timeout_o     (timeout_o[s]),
      .missing_o     (missing_o[NUM_CORES*s +: NUM_CORES]),
      .last_latency_o(last_latency_o[CNT_W*s +: CNT_W])
    );
  end

  logic [3:0]       n_cap;
  logic [16:0]      cnt_sum;
  logic [15:0]      count_nxt;
  logic [CNT_W-1:0] max_nxt;
  logic             err_nxt;

  // Events in the same cycle as clear_i take precedence over the clear.
  always_comb begin
    n_cap   = '0;
    max_nxt = clear_i ? '0 : max_latency_o;
    for (int s = 0; s < NUM_CORES; s++) begin
      n_cap = n_cap + 4'(cap_c[s]);
      if (done_c[s] && (lat_c[CNT_W*s +: CNT_W] > max_nxt)) begin
        max_nxt = lat_c[CNT_W*s +: CNT_W];
      end
    end
    cnt_sum   = 17'(clear_i ? 16'h0000 : bcast_count_o) + 17'(n_cap);
    count_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    err_nxt   = (|to_c) || (err_sticky_o && !clear_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_count_o <= '0;
      max_latency_o <= '0;
      err_sticky_o  <= 1'b0;
    end else begin
      bcast_count_o <= count_nxt;
      max_latency_o <= max_nxt;
      err_sticky_o  <= err_nxt;
    end
  end

endmodule

// File: doc/mesi_isc_bcast_monitor.md
Name: mesi_isc_bcast_monitor

Overview:
Synthesizable, parametrised broadcast-coherence monitor bound alongside mesi_isc.
- For every source core issuing a write or read broadcast on the main bus, it tracks which of the other cores have received the matching snoop on the coherence bus within a bounded window.
- Reports per-source completion, latency, timeout, and the set of cores that were never snooped.
- Generalises the fixed core-3 write-broadcast check to N cores, both broadcast types, address matching and latency statistics.

Parameters:
NUM_CORES, 4, number of cores/ports on mbus and cbus (2..8)
ADDR_WIDTH, 32, main/coherence bus address width
TIMEOUT, 100, last cycle offset (inclusive) at which a snoop is still accepted
CNT_W, $clog2(TIMEOUT+1), latency counter width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable_i  in  1  0 = no new captures; in-flight tracking continues
clear_i  in  1  clears err_sticky_o, max_latency_o, bcast_count_o
mbus_cmd_i  in  NUM_CORES*3  main-bus command per core, core c at [3c+2:3c]
mbus_addr_i  in  NUM_CORES*ADDR_WIDTH  main-bus address per core
cbus_cmd_i  in  NUM_CORES*3  observed mesi_isc cbus_cmd per core
cbus_addr_i  in  ADDR_WIDTH  observed shared cbus_addr
done_o  out  NUM_CORES  1-cycle pulse: source s fully snooped
timeout_o  out  NUM_CORES  1-cycle pulse: source s window expired
missing_o  out  NUM_CORES*NUM_CORES  row s = cores not snooped at timeout of s (held until next capture of s)
last_latency_o  out  NUM_CORES*CNT_W  latency of last completed broadcast of s
max_latency_o  out  CNT_W  maximum completed latency, all sources
bcast_count_o  out  16  captured broadcasts, saturating at 16'hFFFF
err_sticky_o  out  1  set by any timeout, cleared by rst/clear_i

Behaviour:
- Reset (sync, rst=1 at posedge): all trackers IDLE; every output is 0.
- Reset mid-operation discards all in-flight tracking and produces no pulse.
- Per-source FSM with states IDLE, WAIT and HOLD.
- IDLE -> WAIT when enable_i=1 and mbus_cmd[s] is WR_BROAD(3) or RD_BROAD(4). On capture:
  - addr := mbus_addr[s]
  - exp := WR_SNOOP(1) for WR_BROAD, RD_SNOOP(2) for RD_BROAD
  - pend := all ones except bit s
  - cnt := 0
  - missing row s := 0
  - bcast_count_o increments
- Snoop match, evaluated every cycle including the capture cycle: for each core c with pend[c]=1, the bit clears when cbus_cmd[c]==exp and cbus_addr_i==addr.
  - Capture-cycle matches use the captured values.
  - Multiple cores may clear in the same cycle.
- WAIT, per cycle:
  - If pend after clears == 0: done_o[s] pulses, last_latency[s] := cnt, max_latency updates if cnt is greater, then -> HOLD.
  - Else if cnt == TIMEOUT: timeout_o[s] pulses, missing row s := pend after clears, err_sticky_o := 1, then -> HOLD.
  - Else cnt := cnt+1.
- Acceptance window is offsets 0..TIMEOUT inclusive. A match in the capture cycle gives latency 0.
- HOLD -> IDLE on the first cycle mbus_cmd[s] is not a broadcast. This prevents recapturing a command the requester is still holding. Re-capture is possible on the following cycle at the earliest.
- Non-broadcast commands (NOP, WR, RD) are ignored.
- Concurrent sources are tracked independently. A single snoop clears matching bits in every WAIT tracker whose exp and addr both match.
- clear_i clears only the statistics/sticky outputs, not FSMs or missing_o. If clear_i and a timeout or done occur in the same cycle, the event wins: err_sticky_o=1, max_latency_o=new latency.
- enable_i low does not abort WAIT or HOLD.

Decomposition:
- Package mesi_isc_pkg:
  - MBUS cmd constants: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4
  - CBUS cmd constants: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4
  - tracker state enum {IDLE, WAIT, HOLD}
  - function mapping broadcast cmd to expected snoop cmd
- Sub-module mesi_isc_bcast_tracker: one per source, generated NUM_CORES times. It holds FSM, addr, exp, pend, cnt and emits done/timeout/latency/missing.
- Top-level logic: count, max, sticky.

Test Plan:
- NUM_CORES=4. Core3 WR_BROAD addr 0x1000 for 2 cycles. cbus_cmd0/1/2=1, addr 0x1000, at offsets 2/5/7. Expect done_o[3] at offset 7, last_latency[3]=7, bcast_count=1, no timeout.
- Core1 RD_BROAD addr 0x20. Cores 0 and 2 get RD_SNOOP at offset 3; core 3 never does. Expect timeout_o[1] at offset 100, missing row 1 = 4'b1000, err_sticky_o=1.
- Core0 WR_BROAD addr 0x40. cbus_cmd1..3=2 (wrong type), then WR_SNOOP with addr 0x44. Expect no bit cleared, timeout at 100, missing row 0 = 4'b1110.
- Core2 WR_BROAD; all three snoops in the capture cycle. Expect done_o[2] that cycle, latency 0. mbus_cmd2 held 5 more cycles: no re-capture, bcast_count stays 1.
- Core3 and core0 WR_BROAD on the same cycle with different addresses, snoops interleaved. Both done independently with correct latencies; max_latency_o equals the larger of the two.
- Core2 broadcast with 2 of 3 snoops seen, then rst at offset 10. All outputs 0, no pulse. After reset, clear_i following an error clears err_sticky_o; asserting clear_i in a timeout cycle leaves err_sticky_o=1.
